// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } arbStateT;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ownerT;

  localparam int MaxAddrW = 64;

  function automatic int beatBytes(int dataW);
    return dataW / 8;
  endfunction

  // Clears the byte-within-line bits of an address.
  function automatic logic [MaxAddrW-1:0] offsetMask(int lineBytes);
    return ~(MaxAddrW'(lineBytes) - MaxAddrW'(1));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_rvalid;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_done;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_wnext;
  logic              dc_rvalid;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_done;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output ic_rvalid, ic_rdata, ic_done, dc_wnext, dc_rvalid, dc_rdata, dc_done,
           mem_valid, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  ic_rvalid, ic_rdata, ic_done, dc_wnext, dc_rvalid, dc_rdata, dc_done,
           mem_valid, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_prio.sv
// D-priority grant with an anti-starvation counter that forces an I grant
// after STARVE_MAX consecutive D grants while I is waiting.
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arbEn,
  input  logic icReq,
  input  logic dcReq,
  output logic grantValid,
  output logic grantI
);

  localparam int StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveCap = StarveW'(STARVE_MAX);

  logic [StarveW-1:0] starve;
  logic               forceI;
  logic               grantD;

  assign forceI     = icReq && (starve == StarveCap);
  assign grantI     = arbEn && icReq && (!dcReq || forceI);
  assign grantD     = arbEn && dcReq && !forceI;
  assign grantValid = grantI || grantD;

  // A D grant reaching the increment branch implies icReq is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve <= '0;
    end else if (grantI || (arbEn && !icReq)) begin
      starve <= '0;
    end else if (grantD && (starve != StarveCap)) begin
      starve <= starve + StarveW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one beat-serial memory port between I-cache refills and D-cache
// refills/writebacks; each request is a LINE_BEATS-beat burst.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 4,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int BeatBytes = beatBytes(DATA_W);
  localparam int BeatShift = $clog2(BeatBytes);
  localparam int LineBytes = LINE_BEATS * BeatBytes;
  localparam int BeatW     = $clog2(LINE_BEATS);
  localparam logic [ADDR_W-1:0] OffMask  = ADDR_W'(offsetMask(LineBytes));
  localparam logic [BeatW-1:0]  LastBeat = BeatW'(LINE_BEATS - 1);

  arbStateT          state;
  ownerT             owner;
  logic [BeatW-1:0]  beat;
  logic [ADDR_W-1:0] baseAddr;
  logic              weLatch;

  logic arbEn;
  logic grantValid;
  logic grantI;
  logic inAddr;
  logic accept;
  logic respHit;
  logic lastBeat;

  assign arbEn    = (state == IDLE);
  assign inAddr   = (state == ADDR);
  assign accept   = inAddr && bus.mem_ready;
  assign respHit  = (state == RESP) && bus.mem_rvalid;
  assign lastBeat = (beat == LastBeat);

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) uPrio (
    .clk        (clk),
    .rst        (rst),
    .arbEn      (arbEn),
    .icReq      (bus.ic_req),
    .dcReq      (bus.dc_req),
    .grantValid (grantValid),
    .grantI     (grantI)
  );

  // NOTE: state is updated only with non-blocking assignments so every branch
  // reads the pre-edge values; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= OWN_D;
      beat     <= '0;
      baseAddr <= '0;
      weLatch  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            owner    <= grantI ? OWN_I : OWN_D;
            baseAddr <= (grantI ? bus.ic_addr : bus.dc_addr) & OffMask;
            weLatch  <= grantI ? 1'b0 : bus.dc_we;
            beat     <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (bus.mem_ready) begin
            if (!weLatch) begin
              state <= RESP;
            end else if (lastBeat) begin
              state <= DONE;
            end else begin
              beat <= beat + BeatW'(1);
            end
          end
        end
        RESP: begin
          if (bus.mem_rvalid) begin
            if (lastBeat) begin
              state <= DONE;
            end else begin
              beat  <= beat + BeatW'(1);
              state <= ADDR;
            end
          end
        end
        DONE: begin
          beat  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = inAddr;
  assign bus.mem_we    = inAddr && weLatch;
  assign bus.mem_addr  = baseAddr + (ADDR_W'(beat) << BeatShift);
  assign bus.mem_wdata = (inAddr && weLatch) ? bus.dc_wdata : '0;

  // Read data is a same-cycle pass-through, steered to the burst owner only.
  assign bus.ic_rvalid = respHit && (owner == OWN_I);
  assign bus.dc_rvalid = respHit && (owner == OWN_D);
  assign bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : '0;
  assign bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : '0;

  assign bus.dc_wnext = accept && weLatch && (owner == OWN_D);
  assign bus.ic_done  = (state == DONE) && (owner == OWN_I);
  assign bus.dc_done  = (state == DONE) && (owner == OWN_D);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory responder and cache requesters
// drive the port, a per-cycle log collects events, checks compare against hand values.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .LINE_BEATS(4), .STARVE_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checkCnt = 0;
  int failCnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rdataFor(input logic [63:0] a);
    return a ^ 64'hC0FF_EE00_0000_0000;
  endfunction

  function automatic logic [63:0] wdataFor(input int k);
    return 64'hD0D0_0000_0000_0000 | 64'(k);
  endfunction

  // Event log, cleared per test
  int cyc, icDoneCnt, dcDoneCnt, wnextCnt, busyNoValid, stallViol;
  int icDoneCyc, dcDoneCyc, lastIcRvCyc;
  logic [63:0] accAddr[$];
  logic [63:0] accWdata[$];
  logic        accWe[$];
  int          accCyc[$];
  logic [63:0] icData[$];
  logic [63:0] dcData[$];
  logic        doneOrder[$];  // 1 = D burst, 0 = I burst

  // Responder / requester state
  int stall, waitCnt, dcBurstsLeft, wbeat;
  logic manualMem, respPending, sawAcc, sawValid, sawWnext, sawIcDone, sawDcDone, prevStalled;
  logic [63:0] respAddr, prevAddr;

  task automatic clearLog();
    icDoneCnt = 0; dcDoneCnt = 0; wnextCnt = 0; busyNoValid = 0; stallViol = 0;
    icDoneCyc = 0; dcDoneCyc = 0; lastIcRvCyc = 0;
    accAddr.delete(); accWdata.delete(); accWe.delete(); accCyc.delete();
    icData.delete(); dcData.delete(); doneOrder.delete();
  endtask

  task automatic sampleHalf();
    @(negedge clk);
    cyc++;
    if (bus.ic_rvalid) begin icData.push_back(bus.ic_rdata); lastIcRvCyc = cyc; end
    if (bus.dc_rvalid) dcData.push_back(bus.dc_rdata);
    if (bus.ic_done) begin icDoneCnt++; icDoneCyc = cyc; doneOrder.push_back(1'b0); end
    if (bus.dc_done) begin dcDoneCnt++; dcDoneCyc = cyc; doneOrder.push_back(1'b1); end
    if (bus.dc_wnext) wnextCnt++;
    if (bus.busy && !bus.mem_valid) busyNoValid++;
    if (prevStalled && bus.mem_valid && (bus.mem_addr !== prevAddr)) stallViol++;
    prevStalled = bus.mem_valid && !bus.mem_ready;
    prevAddr    = bus.mem_addr;
    sawValid    = bus.mem_valid;
    sawAcc      = bus.mem_valid && bus.mem_ready;
    if (sawAcc) begin
      accAddr.push_back(bus.mem_addr);
      accWdata.push_back(bus.mem_wdata);
      accWe.push_back(bus.mem_we);
      accCyc.push_back(cyc);
      if (!bus.mem_we) begin respPending = 1'b1; respAddr = bus.mem_addr; end
    end
    sawWnext  = bus.dc_wnext;
    sawIcDone = bus.ic_done;
    sawDcDone = bus.dc_done;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
    if (sawIcDone) bus.ic_req = 1'b0;
    if (sawDcDone) begin
      if (dcBurstsLeft > 1) dcBurstsLeft--;
      else begin dcBurstsLeft = 0; bus.dc_req = 1'b0; end
    end
    if (sawWnext) begin wbeat++; bus.dc_wdata = wdataFor(wbeat); end
    if (!manualMem) begin
      bus.mem_rvalid = respPending;
      bus.mem_rdata  = respPending ? rdataFor(respAddr) : 64'h0;
      respPending    = 1'b0;
      if (sawAcc) waitCnt = 0;
      else if (sawValid) waitCnt++;
      bus.mem_ready = (waitCnt >= stall);
    end
  endtask

  task automatic tick();
    stepEdge();
    sampleHalf();
  endtask

  task automatic waitDone(input string tag, input int ic, input int dc, input int budget);
    for (int i = 0; i < budget && (icDoneCnt < ic || dcDoneCnt < dc); i++) tick();
    tick();
    tick();
    check({tag, "_ic_done_cnt"}, icDoneCnt, ic);
    check({tag, "_dc_done_cnt"}, dcDoneCnt, dc);
  endtask

  task automatic idleInputs();
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    manualMem = 1'b0; respPending = 1'b0; waitCnt = 0; stall = 0; dcBurstsLeft = 0; wbeat = 0;
    sawAcc = 1'b0; sawValid = 1'b0; sawWnext = 1'b0; sawIcDone = 1'b0; sawDcDone = 1'b0;
    prevStalled = 1'b0; prevAddr = '0; respAddr = '0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checkCnt, failCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    rst = 1'b0;
    idleInputs();
    clearLog();

    // Reset state
    tick();
    tick();
    check("rst_busy",      bus.busy, 0);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_ic_rvalid", bus.ic_rvalid, 0);
    check("rst_dc_rvalid", bus.dc_rvalid, 0);
    check("rst_ic_done",   bus.ic_done, 0);
    check("rst_dc_done",   bus.dc_done, 0);
    check("rst_dc_wnext",  bus.dc_wnext, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_ic_rdata",  bus.ic_rdata, 0);
    rst = 1'b1;
    tick();

    // 1: I read burst, unaligned address, no stalls
    clearLog();
    bus.ic_addr = 64'h8000_0010;
    bus.ic_req  = 1'b1;
    waitDone("t1", 1, 0, 60);
    check("t1_beats", accAddr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_addr%0d", k), accAddr[k], 64'h8000_0000 + 64'(8 * k));
      check($sformatf("t1_data%0d", k), icData[k], rdataFor(64'h8000_0000 + 64'(8 * k)));
    end
    check("t1_rvalid_cnt", icData.size(), 4);
    check("t1_serialized", accCyc[1] - accCyc[0], 2);
    check("t1_done_lat",   icDoneCyc - lastIcRvCyc, 1);
    check("t1_dc_rvalid",  dcData.size(), 0);

    // 2: D writeback with 3 stall cycles per beat
    clearLog();
    stall = 3; waitCnt = 0; bus.mem_ready = 1'b0;
    wbeat = 0; bus.dc_wdata = wdataFor(0);
    bus.dc_we = 1'b1; bus.dc_addr = 64'h100; dcBurstsLeft = 1; bus.dc_req = 1'b1;
    waitDone("t2", 0, 1, 200);
    check("t2_beats", accAddr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_addr%0d", k),  accAddr[k], 64'h100 + 64'(8 * k));
      check($sformatf("t2_wdata%0d", k), accWdata[k], wdataFor(k));
      check($sformatf("t2_we%0d", k),    accWe[k], 1);
    end
    check("t2_stall_gap",   accCyc[1] - accCyc[0], 4);
    check("t2_wnext_cnt",   wnextCnt, 4);
    check("t2_addr_stable", stallViol, 0);
    check("t2_no_resp",     busyNoValid, 1);
    check("t2_dc_rvalid",   dcData.size(), 0);
    stall = 0; waitCnt = 0; bus.mem_ready = 1'b1; bus.dc_we = 1'b0;

    // 4: back-to-back D reads starve I until the counter forces an I grant
    clearLog();
    bus.ic_addr = 64'h4000; bus.dc_addr = 64'h3000;
    dcBurstsLeft = 5; bus.dc_req = 1'b1; bus.ic_req = 1'b1;
    waitDone("t4", 1, 5, 400);
    check("t4_order_cnt", doneOrder.size(), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("t4_order%0d", k), doneOrder[k], (k == 4) ? 1'b0 : 1'b1);
    check("t4_i_addr", accAddr[16], 64'h4000);

    // 3: simultaneous requests; D first, I right after dc_done (starve was cleared)
    clearLog();
    bus.dc_addr = 64'h500; bus.ic_addr = 64'h600;
    dcBurstsLeft = 1; bus.dc_req = 1'b1; bus.ic_req = 1'b1;
    waitDone("t3", 1, 1, 120);
    check("t3_first_d",  doneOrder[0], 1);
    check("t3_then_i",   doneOrder[1], 0);
    check("t3_d_data0",  dcData[0], rdataFor(64'h500));
    check("t3_i_addr",   accAddr[4], 64'h600);
    check("t3_i_gap",    accCyc[4] - dcDoneCyc, 2);
    check("t3_i_beats",  icData.size(), 4);

    // 5: reset during RESP of beat 2, late response ignored, fresh burst
    clearLog();
    bus.ic_addr = 64'h2000; bus.ic_req = 1'b1;
    for (int i = 0; i < 50 && accAddr.size() < 3; i++) tick();
    check("t5_third_beat", accAddr.size(), 3);
    manualMem = 1'b1;
    stepEdge();
    bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b0; rst = 1'b0;
    sampleHalf();
    check("t5_in_resp", bus.busy && !bus.mem_valid, 1);
    stepEdge();
    rst = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = rdataFor(64'h2010);
    sampleHalf();
    check("t5_busy",      bus.busy, 0);
    check("t5_mem_valid", bus.mem_valid, 0);
    check("t5_ic_rvalid", bus.ic_rvalid, 0);
    check("t5_dc_rvalid", bus.dc_rvalid, 0);
    stepEdge();
    bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b1;
    respPending = 1'b0; waitCnt = 0; manualMem = 1'b0;
    clearLog();
    sampleHalf();
    waitDone("t5", 1, 0, 60);
    check("t5_beats",   accAddr.size(), 4);
    check("t5_addr0",   accAddr[0], 64'h2000);
    check("t5_rv_cnt",  icData.size(), 4);
    check("t5_data0",   icData[0], rdataFor(64'h2000));

    // 6: spurious mem_rvalid in IDLE and ADDR
    clearLog();
    manualMem = 1'b1;
    stepEdge();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; bus.mem_ready = 1'b0;
    sampleHalf();
    check("t6_idle_ic_rvalid", bus.ic_rvalid, 0);
    check("t6_idle_dc_rvalid", bus.dc_rvalid, 0);
    check("t6_idle_ic_rdata",  bus.ic_rdata, 0);
    stepEdge();
    bus.ic_addr = 64'h7000; bus.ic_req = 1'b1;
    sampleHalf();
    check("t6_idle_busy", bus.busy, 0);
    stepEdge();
    sampleHalf();
    check("t6_addr_valid",     bus.mem_valid, 1);
    check("t6_addr_ic_rvalid", bus.ic_rvalid, 0);
    check("t6_addr_mem_addr",  bus.mem_addr, 64'h7000);
    stepEdge();
    bus.mem_rvalid = 1'b0;
    sampleHalf();
    check("t6_still_addr", bus.mem_valid, 1);
    check("t6_still_beat0", bus.mem_addr, 64'h7000);
    stepEdge();
    bus.mem_ready = 1'b1; respPending = 1'b0; waitCnt = 0; manualMem = 1'b0;
    clearLog();
    sampleHalf();
    waitDone("t6", 1, 0, 60);
    check("t6_beats", accAddr.size(), 4);
    check("t6_addr3", accAddr[3], 64'h7018);
    check("t6_data0", icData[0], rdataFor(64'h7000));
    check("t6_rv_cnt", icData.size(), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

endmodule
